// File: rtl/axis_frame_generator.sv
// AXI-Stream video frame source: programmable width x height, SOF on tuser,
// EOL on tlast, frames launched on a programmable period in clocks.
module axis_frame_generator #(
  parameter int AXIS_DATA_WIDTH = 8,
  parameter int IMG_WIDTH_MAX   = 16,
  parameter int IMG_HEIGHT_MAX  = 16
) (
  input  logic                       i_axi_clk,
  input  logic                       i_axi_rst,
  input  logic                       i_enable,
  input  logic [IMG_WIDTH_MAX-1:0]   i_width,
  input  logic [IMG_HEIGHT_MAX-1:0]  i_height,
  input  logic [31:0]                i_frame_period,
  input  logic [1:0]                 i_pattern,
  input  logic [AXIS_DATA_WIDTH-1:0] i_constant,
  output logic                       o_axis_out_tuser,
  output logic                       o_axis_out_tvalid,
  input  logic                       i_axis_out_tready,
  output logic                       o_axis_out_tlast,
  output logic [AXIS_DATA_WIDTH-1:0] o_axis_out_tdata,
  output logic                       o_busy,
  output logic [31:0]                o_frame_count,
  output logic                       o_overrun
);

  localparam logic [IMG_WIDTH_MAX-1:0]   W_ONE = IMG_WIDTH_MAX'(1);
  localparam logic [IMG_HEIGHT_MAX-1:0]  H_ONE = IMG_HEIGHT_MAX'(1);
  localparam logic [AXIS_DATA_WIDTH-1:0] D_ONE = AXIS_DATA_WIDTH'(1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  state_t                       state_q, state_d;
  logic                         first_q, first_d;
  logic [31:0]                  period_cnt_q, period_cnt_d;
  logic [IMG_WIDTH_MAX-1:0]     width_q, width_d;
  logic [IMG_HEIGHT_MAX-1:0]    height_q, height_d;
  logic [1:0]                   pattern_q, pattern_d;
  logic [AXIS_DATA_WIDTH-1:0]   const_q, const_d;
  logic [IMG_WIDTH_MAX-1:0]     x_q, x_d;
  logic [IMG_HEIGHT_MAX-1:0]    y_q, y_d;
  logic [AXIS_DATA_WIDTH-1:0]   pix_q, pix_d;
  logic                         tvalid_q, tvalid_d;
  logic                         tuser_q, tuser_d;
  logic                         tlast_q, tlast_d;
  logic [AXIS_DATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic                         busy_q, busy_d;
  logic [31:0]                  frame_count_q, frame_count_d;
  logic                         overrun_q, overrun_d;

  logic [31:0]                  period_m1;
  logic                         start_ok;
  logic                         beat;
  logic                         at_eol;
  logic                         at_eof;
  logic [IMG_WIDTH_MAX-1:0]     x_next;
  logic [IMG_HEIGHT_MAX-1:0]    y_next;
  logic [AXIS_DATA_WIDTH-1:0]   pix_next;

  function automatic logic [AXIS_DATA_WIDTH-1:0] pixel_value(
    input logic [1:0]                 pattern,
    input logic [AXIS_DATA_WIDTH-1:0] const_val,
    input logic [IMG_WIDTH_MAX-1:0]   x,
    input logic [IMG_HEIGHT_MAX-1:0]  y,
    input logic [AXIS_DATA_WIDTH-1:0] index
  );
    logic [AXIS_DATA_WIDTH-1:0] value;
    case (pattern)
      2'd0:    value = index;
      2'd1:    value = const_val;
      2'd2:    value = AXIS_DATA_WIDTH'(x);
      default: value = AXIS_DATA_WIDTH'(y);
    endcase
    return value;
  endfunction

  // A period of 0 behaves like 1: back-to-back frames.
  assign period_m1 = (i_frame_period == 32'd0) ? 32'd0 : i_frame_period - 32'd1;
  assign start_ok  = i_enable && (i_width != '0) && (i_height != '0) &&
                     (first_q || (period_cnt_q >= period_m1));

  assign beat   = tvalid_q && i_axis_out_tready;
  assign at_eol = (x_q == width_q - W_ONE);
  assign at_eof = at_eol && (y_q == height_q - H_ONE);

  // Running pixel index equals y*width+x modulo the data width.
  assign x_next   = at_eol ? '0 : x_q + W_ONE;
  assign y_next   = at_eol ? y_q + H_ONE : y_q;
  assign pix_next = pix_q + D_ONE;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    first_d       = first_q;
    period_cnt_d  = (period_cnt_q == 32'hFFFF_FFFF) ? period_cnt_q : period_cnt_q + 32'd1;
    width_d       = width_q;
    height_d      = height_q;
    pattern_d     = pattern_q;
    const_d       = const_q;
    x_d           = x_q;
    y_d           = y_q;
    pix_d         = pix_q;
    tvalid_d      = tvalid_q;
    tuser_d       = tuser_q;
    tlast_d       = tlast_q;
    tdata_d       = tdata_q;
    busy_d        = busy_q;
    frame_count_d = frame_count_q;
    overrun_d     = (state_q == ST_ACTIVE) && (i_frame_period >= 32'd2) &&
                    (period_cnt_q == period_m1);

    case (state_q)
      ST_IDLE: begin
        tvalid_d = 1'b0;
        tuser_d  = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
        if (!i_enable) begin
          first_d = 1'b1;
        end
        if (start_ok) begin
          state_d      = ST_ACTIVE;
          first_d      = 1'b0;
          period_cnt_d = 32'd0;
          width_d      = i_width;
          height_d     = i_height;
          pattern_d    = i_pattern;
          const_d      = i_constant;
          x_d          = '0;
          y_d          = '0;
          pix_d        = '0;
          tvalid_d     = 1'b1;
          tuser_d      = 1'b1;
          tlast_d      = (i_width == W_ONE);
          tdata_d      = pixel_value(i_pattern, i_constant, '0, '0, '0);
          busy_d       = 1'b1;
        end
      end

      ST_ACTIVE: begin
        if (beat) begin
          tuser_d = 1'b0;
          if (at_eof) begin
            state_d       = ST_IDLE;
            tvalid_d      = 1'b0;
            tlast_d       = 1'b0;
            busy_d        = 1'b0;
            frame_count_d = frame_count_q + 32'd1;
          end else begin
            x_d     = x_next;
            y_d     = y_next;
            pix_d   = pix_next;
            tlast_d = (x_next == width_q - W_ONE);
            tdata_d = pixel_value(pattern_q, const_q, x_next, y_next, pix_next);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_axi_clk or negedge i_axi_rst) begin
    if (!i_axi_rst) begin
      state_q       <= ST_IDLE;
      first_q       <= 1'b1;
      period_cnt_q  <= '0;
      width_q       <= '0;
      height_q      <= '0;
      pattern_q     <= '0;
      const_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_q         <= '0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      tdata_q       <= '0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      period_cnt_q  <= period_cnt_d;
      width_q       <= width_d;
      height_q      <= height_d;
      pattern_q     <= pattern_d;
      const_q       <= const_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_q         <= pix_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      tdata_q       <= tdata_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
      overrun_q     <= overrun_d;
    end
  end

  assign o_axis_out_tuser  = tuser_q;
  assign o_axis_out_tvalid = tvalid_q;
  assign o_axis_out_tlast  = tlast_q;
  assign o_axis_out_tdata  = tdata_q;
  assign o_busy            = busy_q;
  assign o_frame_count     = frame_count_q;
  assign o_overrun         = overrun_q;

endmodule

// File: tb/tb_axis_frame_generator.sv
// Directed bench for axis_frame_generator: per-cycle vector table plus
// sequences for frame period, overrun, enable drop and mid-frame reset.
module tb_axis_frame_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] width;
  logic [15:0] height;
  logic [31:0] period;
  logic [1:0]  pattern;
  logic [7:0]  cst;
  logic        rdy;
  logic        tuser;
  logic        tvalid;
  logic        tlast;
  logic [7:0]  tdata;
  logic        busy;
  logic [31:0] frame_count;
  logic        overrun;

  always #5 clk = ~clk;

  axis_frame_generator #(
    .AXIS_DATA_WIDTH(8),
    .IMG_WIDTH_MAX  (16),
    .IMG_HEIGHT_MAX (16)
  ) dut (
    .i_axi_clk        (clk),
    .i_axi_rst        (rst_n),
    .i_enable         (en),
    .i_width          (width),
    .i_height         (height),
    .i_frame_period   (period),
    .i_pattern        (pattern),
    .i_constant       (cst),
    .o_axis_out_tuser (tuser),
    .o_axis_out_tvalid(tvalid),
    .i_axis_out_tready(rdy),
    .o_axis_out_tlast (tlast),
    .o_axis_out_tdata (tdata),
    .o_busy           (busy),
    .o_frame_count    (frame_count),
    .o_overrun        (overrun)
  );

  typedef struct {
    logic        en;
    logic        rdy;
    logic [15:0] w;
    logic [15:0] h;
    logic [1:0]  pat;
    logic [7:0]  cst;
    logic        vld;
    logic        usr;
    logic        lst;
    logic [7:0]  dat;
    logic        busy;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(int e, int r, int w, int h, int p, int c,
                              int vld, int usr, int lst, int dat, int bsy, int cnt);
    vec_t v;
    v.en   = e[0];
    v.rdy  = r[0];
    v.w    = w[15:0];
    v.h    = h[15:0];
    v.pat  = p[1:0];
    v.cst  = c[7:0];
    v.vld  = vld[0];
    v.usr  = usr[0];
    v.lst  = lst[0];
    v.dat  = dat[7:0];
    v.busy = bsy[0];
    v.cnt  = cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    en = 1'b0;
    for (int i = 0; i < 80 && busy; i++) step();
    step();
    check(name, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int    sof_t[3];
    int    nsof;
    int    pulses;
    int    wide;
    int    beats;
    int    bad;
    logic  seen;
    logic  ovr_prev;
    logic  found;

    // Frames 1 and 2: w=4 h=2 pattern 0, back-to-back; enable dropped during frame 2.
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, 1, 4, 2, 0, 0, 1, (k == 0) ? 1 : 0, (k == 3 || k == 7) ? 1 : 0, k, 1, 0));
    vecs.push_back(mk(1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk((k == 0) ? 1 : 0, 1, 4, 2, 0, 0, 1, (k == 0) ? 1 : 0,
                        (k == 3 || k == 7) ? 1 : 0, k, 1, 1));
    vecs.push_back(mk(0, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(0, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 2));
    // Pattern 2, w=3 h=1, tready stalls; config scrambled mid-frame.
    vecs.push_back(mk(1, 0, 3, 1, 2, 0, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 0, 9, 5, 0, 0, 1, 1, 0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 9, 5, 0, 0, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 0, 9, 5, 0, 0, 1, 0, 0, 1, 1, 2));
    vecs.push_back(mk(0, 1, 9, 5, 0, 0, 1, 0, 1, 2, 1, 2));
    vecs.push_back(mk(0, 0, 9, 5, 0, 0, 1, 0, 1, 2, 1, 2));
    vecs.push_back(mk(0, 1, 9, 5, 0, 0, 0, 0, 0, 0, 0, 3));
    // Pattern 3, w=2 h=2.
    vecs.push_back(mk(1, 1, 2, 2, 3, 0, 1, 1, 0, 0, 1, 3));
    vecs.push_back(mk(0, 1, 5, 9, 0, 0, 1, 0, 1, 0, 1, 3));
    vecs.push_back(mk(0, 1, 5, 9, 0, 0, 1, 0, 0, 1, 1, 3));
    vecs.push_back(mk(0, 1, 5, 9, 0, 0, 1, 0, 1, 1, 1, 3));
    vecs.push_back(mk(0, 1, 5, 9, 0, 0, 0, 0, 0, 0, 0, 4));
    // Pattern 1 constant, w=1 h=2: every beat is end of line.
    vecs.push_back(mk(1, 1, 1, 2, 1, 165, 1, 1, 1, 165, 1, 4));
    vecs.push_back(mk(0, 1, 1, 2, 1, 60, 1, 0, 1, 165, 1, 4));
    vecs.push_back(mk(0, 1, 1, 2, 1, 60, 0, 0, 0, 0, 0, 5));
    vecs.push_back(mk(0, 1, 1, 2, 1, 60, 0, 0, 0, 0, 0, 5));

    rst_n   = 1'b0;
    en      = 1'b0;
    width   = 16'd0;
    height  = 16'd0;
    period  = 32'd0;
    pattern = 2'd0;
    cst     = 8'd0;
    rdy     = 1'b0;
    step();
    step();
    check("reset_state", 64'({tvalid, tuser, tlast, busy, overrun, tdata, frame_count}), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      en      = vecs[i].en;
      rdy     = vecs[i].rdy;
      width   = vecs[i].w;
      height  = vecs[i].h;
      pattern = vecs[i].pat;
      cst     = vecs[i].cst;
      step();
      check($sformatf("vec%0d", i),
            64'({tvalid, tuser, tlast, busy, (tvalid ? tdata : 8'h00), frame_count}),
            64'({vecs[i].vld, vecs[i].usr, vecs[i].lst, vecs[i].busy,
                 (vecs[i].vld ? vecs[i].dat : 8'h00), vecs[i].cnt}));
    end

    // Zero width or height never starts a frame.
    rdy = 1'b1; width = 16'd0; height = 16'd2; en = 1'b1; seen = 1'b0;
    repeat (6) begin step(); seen |= tvalid; end
    check("zero_width_no_start", 64'(seen), 64'd0);
    width = 16'd2; height = 16'd0; seen = 1'b0;
    repeat (6) begin step(); seen |= tvalid; end
    check("zero_height_no_start", 64'(seen), 64'd0);
    en = 1'b0;
    step();

    // Period 20 with short frames: SOF exactly 20 clocks apart, no overrun.
    width = 16'd4; height = 16'd2; pattern = 2'd0; period = 32'd20; en = 1'b1;
    sof_t = '{0, 0, 0}; nsof = 0; seen = 1'b0;
    for (int c = 0; c < 120 && nsof < 3; c++) begin
      step();
      seen |= overrun;
      if (tvalid && tuser) begin sof_t[nsof] = c; nsof++; end
    end
    check("p20_sof_count", 64'(nsof), 64'd3);
    check("p20_gap1", 64'(sof_t[1] - sof_t[0]), 64'd20);
    check("p20_gap2", 64'(sof_t[2] - sof_t[1]), 64'd20);
    check("p20_no_overrun", 64'(seen), 64'd0);
    drain("p20_drain");

    // Period 8 with 16-beat frames: 17-clock spacing, one overrun per frame.
    width = 16'd4; height = 16'd4; period = 32'd8; en = 1'b1;
    sof_t = '{0, 0, 0}; nsof = 0; pulses = 0; wide = 0; ovr_prev = 1'b0;
    for (int c = 0; c < 200 && nsof < 3; c++) begin
      step();
      if (tvalid && tuser) begin sof_t[nsof] = c; nsof++; end
      if (overrun && nsof >= 1 && nsof < 3) pulses++;
      if (overrun && ovr_prev) wide++;
      ovr_prev = overrun;
    end
    check("p8_sof_count", 64'(nsof), 64'd3);
    check("p8_gap1", 64'(sof_t[1] - sof_t[0]), 64'd17);
    check("p8_gap2", 64'(sof_t[2] - sof_t[1]), 64'd17);
    check("p8_overrun_pulses", 64'(pulses), 64'd2);
    check("p8_overrun_width", 64'(wide), 64'd0);
    drain("p8_drain");

    // Reset asserted while beat 5 is on the bus.
    width = 16'd4; height = 16'd2; period = 32'd0; pattern = 2'd0; en = 1'b1; found = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (tvalid && tdata == 8'd5) begin found = 1'b1; break; end
    end
    check("rst_reached_beat5", 64'(found), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_outputs_low", 64'({tvalid, tuser, tlast, busy, overrun}), 64'd0);
    check("rst_count_cleared", 64'(frame_count), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_fresh_sof", 64'({tvalid, tuser, tdata}), 64'({1'b1, 1'b1, 8'd0}));

    // Enable dropped at beat 2: the frame still completes all 8 beats.
    beats = 0; bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (!tvalid) break;
      if (tdata != 8'(beats)) bad++;
      if (tlast != (beats == 3 || beats == 7)) bad++;
      beats++;
      if (beats == 3) en = 1'b0;
      step();
    end
    check("endrop_beats", 64'(beats), 64'd8);
    check("endrop_data", 64'(bad), 64'd0);
    check("endrop_count", 64'(frame_count), 64'd1);
    seen = 1'b0;
    repeat (6) begin step(); seen |= tvalid; end
    check("endrop_stays_idle", 64'(seen), 64'd0);
    check("endrop_count_hold", 64'(frame_count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
